wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register: the write-back stage plus the architectural register file.
- Selects the write-back value from the WB_* fields, writes it into a 32x32 register file and serves the two decode-stage read ports.
- Exports the selected write-back value and a retired-write counter for the forwarding unit and debug.

---
 rtl/rv_pkg.sv | 37 +++
 rtl/wb_select.sv | 46 ++++
 rtl/wb_regfile.sv | 124 ++++++++++++
 tb/tb_wb_regfile.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 datapath package.
// Provides the register-file geometry, the word / register-address types and
// the write-back source selector code. The helper below encodes the
// write-back priority: a link (JAL/JALR) beats a load, and a load beats the
// ALU result.
package rv_pkg;

  localparam int          XLEN       = 32;
  localparam int          REG_ADDR_W = 5;
  localparam int          NREG       = 32;
  localparam logic [4:0]  REG_ZERO   = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2
  } wb_sel_t;

  // Write-back source decode. JL/JLR together with MD is illegal decode;
  // the link still wins so a bad control word cannot corrupt the return address.
  function automatic wb_sel_t wb_sel_decode(input logic jl, input logic jlr,
                                            input logic md);
    wb_sel_t sel;
    if (jl || jlr) begin
      sel = WB_SEL_PC4;
    end else if (md) begin
      sel = WB_SEL_MEM;
    end else begin
      sel = WB_SEL_ALU;
    end
    return sel;
  endfunction

endpackage

// File: rtl/wb_select.sv
// Write-back source select (purely combinational).
// Ports:
//   i_fout    - ALU / function-unit result
//   i_data_in - load data
//   i_pc4     - PC+4 link value
//   i_md      - select load data
//   i_jl      - JAL in write-back
//   i_jlr     - JALR in write-back
//   o_data    - selected write-back value
//   o_sel     - which source was selected
module wb_select
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_fout,
  input  logic [XLEN-1:0] i_data_in,
  input  logic [XLEN-1:0] i_pc4,
  input  logic            i_md,
  input  logic            i_jl,
  input  logic            i_jlr,
  output logic [XLEN-1:0] o_data,
  output wb_sel_t         o_sel
);

  wb_sel_t w_sel;

  // Priority decode of the write-back source.
  always_comb begin
    w_sel = wb_sel_decode(i_jl, i_jlr, i_md);
  end

  // Three-way data mux driven by the decoded selector.
  always_comb begin
    o_data = i_fout;
    case (w_sel)
      WB_SEL_PC4: o_data = i_pc4;
      WB_SEL_MEM: o_data = i_data_in;
      WB_SEL_ALU: o_data = i_fout;
      default:    o_data = i_fout;
    endcase
  end

  assign o_sel = w_sel;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus architectural register file.
// Selects the write-back value, writes it into the register file (x0 is
// hardwired to zero), serves two combinational read ports and counts
// committed writes.
// Configuration macro: WB_REGFILE_BYPASS_EN
//   defined   - write-through: a read of the register being written returns
//               the new value in the same cycle (suppressed during reset)
//   undefined - reads return the stored value; the hazard unit forwards/stalls
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   WB_Fout/WB_Data_In/WB_Pc4     - candidate write-back values
//   WB_DA, WB_RW                  - destination address, write enable
//   WB_MD, WB_JL, WB_JLR          - write-back source controls
//   AA, BA / A_Data, B_Data       - read ports
//   WB_Data, WB_We                - selected value / effective write enable
//   wr_count                      - committed-write counter (wraps)
module wb_regfile
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  WB_Fout,
  input  logic [XLEN-1:0]  WB_Data_In,
  input  logic [XLEN-1:0]  WB_Pc4,
  input  logic [4:0]       WB_DA,
  input  logic             WB_RW,
  input  logic             WB_MD,
  input  logic             WB_JL,
  input  logic             WB_JLR,
  input  logic [4:0]       AA,
  input  logic [4:0]       BA,
  output logic [XLEN-1:0]  A_Data,
  output logic [XLEN-1:0]  B_Data,
  output logic [XLEN-1:0]  WB_Data,
  output logic             WB_We,
  output logic [CNT_W-1:0] wr_count
);

  logic [XLEN-1:0]  r_regs [1:NREG-1];
  logic [CNT_W-1:0] r_wr_count;

  logic [XLEN-1:0]  w_wb_data;
  wb_sel_t          w_sel;
  logic             w_we;
  logic [XLEN-1:0]  w_a_stored;
  logic [XLEN-1:0]  w_b_stored;
  logic [XLEN-1:0]  w_a_data;
  logic [XLEN-1:0]  w_b_data;

  wb_select #(
    .XLEN (XLEN)
  ) u_wb_select (
    .i_fout    (WB_Fout),
    .i_data_in (WB_Data_In),
    .i_pc4     (WB_Pc4),
    .i_md      (WB_MD),
    .i_jl      (WB_JL),
    .i_jlr     (WB_JLR),
    .o_data    (w_wb_data),
    .o_sel     (w_sel)
  );

  // Writes to x0 are never enabled, so x0 needs no storage.
  assign w_we = WB_RW && (WB_DA != REG_ZERO);

  // Register storage and write counter; reset drops the same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
      r_wr_count <= {CNT_W{1'b0}};
    end else if (w_we) begin
      r_regs[WB_DA] <= w_wb_data;
      r_wr_count    <= r_wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_wr_count <= r_wr_count;
    end
  end

  // Stored-value read; address 0 always returns zero.
  always_comb begin
    if (AA == REG_ZERO) begin
      w_a_stored = {XLEN{1'b0}};
    end else begin
      w_a_stored = r_regs[AA];
    end
    if (BA == REG_ZERO) begin
      w_b_stored = {XLEN{1'b0}};
    end else begin
      w_b_stored = r_regs[BA];
    end
  end

  // Read-port output, optionally forwarding the in-flight write.
  always_comb begin
    w_a_data = w_a_stored;
    w_b_data = w_b_stored;
`ifdef WB_REGFILE_BYPASS_EN
    // w_we already excludes x0, so the zero register is never bypassed.
    if (!rst && w_we && (AA == WB_DA)) begin
      w_a_data = w_wb_data;
    end else begin
      w_a_data = w_a_stored;
    end
    if (!rst && w_we && (BA == WB_DA)) begin
      w_b_data = w_wb_data;
    end else begin
      w_b_data = w_b_stored;
    end
`endif
  end

  assign A_Data   = w_a_data;
  assign B_Data   = w_b_data;
  assign WB_Data  = w_wb_data;
  assign WB_We    = w_we;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile. Two instances share all inputs: one
// with the default 32-bit counter and one with a 4-bit counter so the wrap
// can be reached quickly. A plain array model plus a write counter provides
// every expected value.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fout, din, pc4;
  logic [4:0]  da, aa, ba;
  logic        rw, md, jl, jlr;

  logic [31:0] a_data, b_data, wb_data;
  logic        wb_we;
  logic [31:0] wr_count;
  logic [31:0] a4_data, b4_data, wb4_data;
  logic        wb4_we;
  logic [3:0]  wr4_count;

  logic [31:0] model_regs [0:31];
  logic [31:0] model_cnt;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .WB_Fout(fout), .WB_Data_In(din), .WB_Pc4(pc4),
    .WB_DA(da), .WB_RW(rw), .WB_MD(md), .WB_JL(jl), .WB_JLR(jlr),
    .AA(aa), .BA(ba), .A_Data(a_data), .B_Data(b_data),
    .WB_Data(wb_data), .WB_We(wb_we), .wr_count(wr_count)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .WB_Fout(fout), .WB_Data_In(din), .WB_Pc4(pc4),
    .WB_DA(da), .WB_RW(rw), .WB_MD(md), .WB_JL(jl), .WB_JLR(jlr),
    .AA(aa), .BA(ba), .A_Data(a4_data), .B_Data(b4_data),
    .WB_Data(wb4_data), .WB_We(wb4_we), .wr_count(wr4_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] d,
                       input logic [31:0] f, input logic [31:0] di,
                       input logic [31:0] p, input logic m, input logic j,
                       input logic jr, input logic [4:0] a, input logic [4:0] b);
    rst = r; rw = w; da = d; fout = f; din = di; pc4 = p;
    md = m; jl = j; jlr = jr; aa = a; ba = b;
  endtask

  // Expected register read given the current inputs and the model state.
  function automatic logic [31:0] exp_read(input logic [4:0] addr, input logic [31:0] wbv);
    if (addr == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (!rst && rw && da != 5'd0 && addr == da) return wbv;
`endif
    return model_regs[addr];
  endfunction

  // Check all outputs mid-cycle, then clock and update the model.
  task automatic cycle(input string tag);
    logic [31:0] wbv;
    logic        we;
    @(negedge clk);
    wbv = (jl || jlr) ? pc4 : (md ? din : fout);
    we  = rw && (da != 5'd0);
    check({tag, ".wb_data"}, wb_data, wbv);
    check({tag, ".wb_we"}, {31'd0, wb_we}, {31'd0, we});
    check({tag, ".a_data"}, a_data, exp_read(aa, wbv));
    check({tag, ".b_data"}, b_data, exp_read(ba, wbv));
    check({tag, ".wr_count"}, wr_count, model_cnt);
    check({tag, ".wr4_count"}, {28'd0, wr4_count}, {28'd0, model_cnt[3:0]});
    check({tag, ".a4_data"}, a4_data, exp_read(aa, wbv));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_cnt = 32'd0;
    end else if (we) begin
      model_regs[da] = wbv;
      model_cnt = model_cnt + 32'd1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_cnt = 32'd0;
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    @(posedge clk); #1;

    // All registers read zero after reset.
    for (int i = 0; i < 32; i += 2) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'(i), 5'(i + 1));
      cycle("reset_read");
    end

    // Source precedence: ALU, load, link over load.
    drive(1'b0, 1'b1, 5'd5, 32'h1234, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0);
    cycle("wr_alu");
    drive(1'b0, 1'b1, 5'd6, 32'h1111, 32'hDEADBEEF, 32'hBBBB, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5);
    cycle("wr_mem");
    drive(1'b0, 1'b1, 5'd1, 32'h2222, 32'hCAFEF00D, 32'h104, 1'b1, 1'b0, 1'b1, 5'd6, 5'd5);
    cycle("wr_jlr");
    drive(1'b0, 1'b1, 5'd9, 32'h3333, 32'h4444, 32'h208, 1'b0, 1'b1, 1'b0, 5'd1, 5'd6);
    cycle("wr_jl");
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd9);
    cycle("rd_back");
    check("x1_link", a_data, 32'h104);
    check("x6_load", model_regs[6], 32'hDEADBEEF);

    // x0 protection.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    cycle("x0_write");
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    cycle("x0_read");

    // Same-cycle read and write of one register.
    drive(1'b0, 1'b1, 5'd7, 32'h11, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    cycle("x7_init");
    drive(1'b0, 1'b1, 5'd7, 32'h22, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7);
    cycle("x7_collide");
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7);
    cycle("x7_after");
    check("x7_next", b_data, 32'h22);

    // Reset coinciding with a write.
    drive(1'b1, 1'b1, 5'd3, 32'h55, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd7);
    cycle("rst_collide");
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd7);
    cycle("rst_after");

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 5'd2, 32'(i * 3 + 1), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0);
      cycle("wrap_wr");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd2, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd2);
      cycle("wrap_idle");
    end
    check("wrap4_zero", {28'd0, wr4_count}, 32'd0);
    check("wrap32_16", wr_count, 32'd16);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 39) == 0), 1'($urandom), d, $urandom, $urandom, $urandom,
            1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
